divisor_algoritmico: RTL and testbench
======================================

// Module: divisor_algoritmico
// PURPOSE
//  Sequential signed integer divider (restoring algorithm, one quotient bit per clock).
//  Accepts two's-complement Num/Den on Start and returns quotient Coc and remainder Res.
//  The quotient truncates toward zero; the remainder takes the sign of Num. Completion is flagged by a Done pulse.
//  Standalone arithmetic unit for multi-cycle datapaths where a combinational divider is too large.
// PARAMETERS
//  tamanyo  32  operand/result width in bits (two's complement); legal range >= 4
// PORTS
//  CLK    in   1        single clock, rising edge
//  RSTa   in   1        reset, asynchronous, active-high
//  Start  in   1        level request; sampled only in IDLE
//  Num    in   tamanyo  dividend, signed
//  Den    in   tamanyo  divisor, signed
//  Done   out  1        one-cycle completion pulse; Coc/Res valid from this cycle
//  Coc    out  tamanyo  quotient, signed
//  Res    out  tamanyo  remainder, signed
// BEHAVIOUR
//  - Reset: asserting RSTa (any time, including mid-division) forces IDLE. Done=0, Coc=0 and Res=0.
//  - FSM states: IDLE, CALC, FIN.
//  - IDLE -> CALC on the rising edge with Start=1:
//    latch |Num| and |Den| as unsigned tamanyo-bit values;
//    latch sNum = Num[MSB] and sCoc = Num[MSB]^Den[MSB];
//    clear the partial remainder; load cnt = tamanyo.
//  - CALC, each edge: shift {R,Q} left by 1; trial = R - |Den| (tamanyo+1 bits).
//    If trial >= 0, then R = trial and Q[0] = 1; otherwise Q[0] = 0. Decrement cnt.
//    Go to FIN after the tamanyo-th step.
//  - FIN, one cycle: Coc = sCoc ? -Q : Q and Res = sNum ? -R : R are registered, and Done = 1.
//    Next edge -> IDLE.
//  - Latency: Done rises tamanyo+1 edges after the edge that sampled Start.
//    Done is high for exactly one cycle.
//  - Coc/Res hold their values until the next FIN or reset. Num/Den may change freely after the Start edge.
//  - Start asserted during CALC/FIN is ignored. If Start is still high when IDLE is re-entered,
//    a new division begins; callers drop Start on Done.
//  - Width rules: magnitudes are computed in tamanyo bits unsigned, so Num = -2^(tamanyo-1) is handled.
//    Results wrap modulo 2^tamanyo, so -2^(tamanyo-1) / -1 gives Coc = -2^(tamanyo-1), Res = 0.
//  - Den == 0: no error flag. The algorithm yields Q = all ones and R = |Num|,
//    then the sign rules apply. With Num >= 0 this gives Coc = -1 and Res = Num.
//  - Registers are written only on CLK rising edges (plus async reset).
//    The combinational subtract/shift lives in one step.
// STRUCTURE
//  - Package divisor_pkg: typedef enum logic [1:0] {IDLE, CALC, FIN} estado_t.
//  - Sub-module divisor_paso (combinational, parameter tamanyo):
//    inputs R, Q, D; outputs the next R and Q for one restoring iteration.
//  - Top: FSM, counter ($clog2(tamanyo)+1 bits), operand/sign registers, output registers.
// TESTING
//  (each: Start=1 after reset release, wait posedge Done, drop Start, check; tamanyo=32)
//  - Both positive: 15/3 -> Coc=5, Res=0; 17/3 -> Coc=5, Res=2.
//  - Positive Num, negative Den: 15/-3 -> Coc=-5, Res=0; 17/-3 -> Coc=-5, Res=2.
//  - Both negative: -15/-3 -> Coc=5, Res=0; -23/-5 -> Coc=4, Res=-3.
//  - Negative Num, positive Den: -17/3 -> Coc=-5, Res=-2; -18/3 -> Coc=-6, Res=0.
//  - Timing/handshake: Done rises exactly 33 edges after the Start edge and is high for 1 cycle.
//    Num/Den changed mid-CALC do not alter the result. RSTa pulse mid-CALC -> Done never fires and outputs = 0.
//  - Corners: Den=0 with Num=7 -> Coc=-1, Res=7.
//    Num=-2^31, Den=-1 -> Coc=-2^31, Res=0.
//    Num=-2^31, Den=1 -> Coc=-2^31, Res=0.

Source files
------------

// File: rtl/divisor_pkg.sv
// Shared types for the sequential restoring divider.
package divisor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } estado_t;

endpackage

// File: rtl/divisor_paso.sv
// One restoring-division iteration: shift {R,Q} left, subtract D if it fits.
module divisor_paso #(
  parameter int tamanyo = 32
) (
  input  logic [tamanyo-1:0] r_i,
  input  logic [tamanyo-1:0] q_i,
  input  logic [tamanyo-1:0] d_i,
  output logic [tamanyo-1:0] r_o,
  output logic [tamanyo-1:0] q_o
);

  logic [tamanyo:0] desp;
  logic             cabe;

  // The extra top bit matters only when D == 0 lets R grow past the usual R < D bound.
  always_comb begin
    desp = {r_i, q_i[tamanyo-1]};
    cabe = (desp >= {1'b0, d_i});
    if (cabe) begin
      r_o = desp[tamanyo-1:0] - d_i;
      q_o = {q_i[tamanyo-2:0], 1'b1};
    end else begin
      r_o = desp[tamanyo-1:0];
      q_o = {q_i[tamanyo-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/divisor_algoritmico.sv
// Sequential signed divider: one quotient bit per clock, quotient truncates toward zero,
// remainder follows the sign of the dividend.
module divisor_algoritmico
  import divisor_pkg::*;
#(
  parameter int tamanyo = 32
) (
  input  logic                      CLK,
  input  logic                      RSTa,
  input  logic                      Start,
  input  logic signed [tamanyo-1:0] Num,
  input  logic signed [tamanyo-1:0] Den,
  output logic                      Done,
  output logic signed [tamanyo-1:0] Coc,
  output logic signed [tamanyo-1:0] Res
);

  localparam int CNT_W = $clog2(tamanyo) + 1;

  estado_t                   estado_q;
  logic [CNT_W-1:0]          cnt_q;
  logic                      snum_q;
  logic                      scoc_q;
  logic                      done_q;
  logic signed [tamanyo-1:0] coc_q;
  logic signed [tamanyo-1:0] res_q;
  logic [tamanyo-1:0]        r_q;
  logic [tamanyo-1:0]        q_q;
  logic [tamanyo-1:0]        d_q;
  logic [tamanyo-1:0]        r_d;
  logic [tamanyo-1:0]        q_d;

  // Unsigned magnitude; -2^(tamanyo-1) maps to 2^(tamanyo-1) without overflow.
  function automatic logic [tamanyo-1:0] magnitud(input logic signed [tamanyo-1:0] v);
    return v[tamanyo-1] ? (~$unsigned(v) + 1'b1) : $unsigned(v);
  endfunction

  function automatic logic signed [tamanyo-1:0] con_signo(input logic [tamanyo-1:0] v,
                                                          input logic s);
    return $signed(s ? (~v + 1'b1) : v);
  endfunction

  divisor_paso #(
    .tamanyo(tamanyo)
  ) u_paso (
    .r_i(r_q),
    .q_i(q_q),
    .d_i(d_q),
    .r_o(r_d),
    .q_o(q_d)
  );

  // Operand datapath: loaded on the accepting edge, iterated during CALC.
  always_ff @(posedge CLK) begin
    if (estado_q == IDLE && Start) begin
      r_q <= '0;
      q_q <= magnitud(Num);
      d_q <= magnitud(Den);
    end else if (estado_q == CALC) begin
      r_q <= r_d;
      q_q <= q_d;
    end
  end

  always_ff @(posedge CLK or posedge RSTa) begin
    if (RSTa) begin
      estado_q <= IDLE;
      cnt_q    <= '0;
      snum_q   <= 1'b0;
      scoc_q   <= 1'b0;
      done_q   <= 1'b0;
      coc_q    <= '0;
      res_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (estado_q)
        IDLE: begin
          if (Start) begin
            snum_q   <= Num[tamanyo-1];
            scoc_q   <= Num[tamanyo-1] ^ Den[tamanyo-1];
            cnt_q    <= CNT_W'(tamanyo);
            estado_q <= CALC;
          end
        end
        CALC: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            estado_q <= FIN;
          end
        end
        FIN: begin
          coc_q    <= con_signo(q_q, scoc_q);
          res_q    <= con_signo(r_q, snum_q);
          done_q   <= 1'b1;
          estado_q <= IDLE;
        end
        default: estado_q <= IDLE;
      endcase
    end
  end

  assign Done = done_q;
  assign Coc  = coc_q;
  assign Res  = res_q;

endmodule

// File: tb/tb_divisor_algoritmico.sv
// Randomized and directed checks of the sequential signed divider against an arithmetic model.
module tb_divisor_algoritmico;

  localparam int W = 32;

  logic                CLK;
  logic                RSTa;
  logic                Start;
  logic signed [W-1:0] Num;
  logic signed [W-1:0] Den;
  logic                Done;
  logic signed [W-1:0] Coc;
  logic signed [W-1:0] Res;

  int n_checks;
  int n_errors;

  divisor_algoritmico #(
    .tamanyo(W)
  ) dut (
    .CLK  (CLK),
    .RSTa (RSTa),
    .Start(Start),
    .Num  (Num),
    .Den  (Den),
    .Done (Done),
    .Coc  (Coc),
    .Res  (Res)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)",
               tag, $signed(obs), obs, $signed(exp), exp);
    end
  endtask

  // Reference: truncating division on 64-bit magnitudes, then the sign rules.
  function automatic void modelo(input logic signed [W-1:0] n, input logic signed [W-1:0] d,
                                 output logic [W-1:0] q_exp, output logic [W-1:0] r_exp);
    longint an, ad, qm, rm, q, r;
    an = (n < 0) ? -longint'(n) : longint'(n);
    ad = (d < 0) ? -longint'(d) : longint'(d);
    if (ad == 0) begin
      qm = 64'h0000_0000_FFFF_FFFF;
      rm = an;
    end else begin
      qm = an / ad;
      rm = an % ad;
    end
    q = ((n < 0) != (d < 0)) ? -qm : qm;
    r = (n < 0) ? -rm : rm;
    q_exp = q[W-1:0];
    r_exp = r[W-1:0];
  endfunction

  // Issues one division, optionally scrambling the operands mid-calculation.
  task automatic dividir(input string tag, input logic signed [W-1:0] n,
                         input logic signed [W-1:0] d, input bit cambiar);
    logic [W-1:0] q_exp, r_exp;
    int edges;
    bit vista;
    modelo(n, d, q_exp, r_exp);
    @(negedge CLK);
    Num   = n;
    Den   = d;
    Start = 1'b1;
    @(posedge CLK);
    edges = 0;
    vista = 1'b0;
    while (edges < 60 && !vista) begin
      @(posedge CLK);
      edges++;
      #1;
      if (cambiar && edges == 5) begin
        Num = $signed($urandom);
        Den = $signed($urandom);
      end
      if (Done) vista = 1'b1;
    end
    Start = 1'b0;
    check({tag, ".latency"}, edges, W + 1);
    check({tag, ".coc"}, Coc, q_exp);
    check({tag, ".res"}, Res, r_exp);
    @(posedge CLK);
    #1;
    check({tag, ".done_width"}, {31'b0, Done}, 32'd0);
  endtask

  typedef struct {
    logic signed [W-1:0] n;
    logic signed [W-1:0] d;
  } caso_t;

  initial begin
    caso_t casos[$];
    int done_visto;
    n_checks = 0;
    n_errors = 0;
    RSTa  = 1'b1;
    Start = 1'b0;
    Num   = '0;
    Den   = '0;
    repeat (3) @(posedge CLK);
    #1;
    check("reset.done", {31'b0, Done}, 32'd0);
    check("reset.coc", Coc, 32'd0);
    check("reset.res", Res, 32'd0);
    @(negedge CLK);
    RSTa = 1'b0;

    casos.push_back('{32'sd15, 32'sd3});
    casos.push_back('{32'sd17, 32'sd3});
    casos.push_back('{32'sd15, -32'sd3});
    casos.push_back('{32'sd17, -32'sd3});
    casos.push_back('{-32'sd15, -32'sd3});
    casos.push_back('{-32'sd23, -32'sd5});
    casos.push_back('{-32'sd17, 32'sd3});
    casos.push_back('{-32'sd18, 32'sd3});
    casos.push_back('{32'sd7, 32'sd0});
    casos.push_back('{-32'sd9, 32'sd0});
    casos.push_back('{32'sh8000_0000, -32'sd1});
    casos.push_back('{32'sh8000_0000, 32'sd1});
    casos.push_back('{32'sh7FFF_FFFF, 32'sh8000_0000});
    foreach (casos[i]) dividir($sformatf("dir%0d", i), casos[i].n, casos[i].d, 1'b0);

    dividir("midcalc", 32'sd1000, -32'sd7, 1'b1);

    for (int i = 0; i < 20; i++) begin
      logic signed [W-1:0] rn, rd;
      rn = $signed($urandom);
      rd = (i % 2 == 0) ? $signed(32'($urandom_range(0, 40)) - 32'd20) : $signed($urandom);
      dividir($sformatf("rnd%0d", i), rn, rd, 1'b0);
    end

    // Reset pulse in the middle of a division: no Done and cleared outputs.
    @(negedge CLK);
    Num   = 32'sd100;
    Den   = 32'sd9;
    Start = 1'b1;
    @(posedge CLK);
    #1;
    Start = 1'b0;
    repeat (10) @(posedge CLK);
    #2;
    RSTa = 1'b1;
    #2;
    RSTa = 1'b0;
    done_visto = 0;
    repeat (40) begin
      @(posedge CLK);
      #1;
      if (Done) done_visto++;
    end
    check("rst_mid.done_count", done_visto, 32'd0);
    check("rst_mid.coc", Coc, 32'd0);
    check("rst_mid.res", Res, 32'd0);

    dividir("post_rst", -32'sd17, 32'sd3, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
